gfx_compositor: RTL and testbench
=================================

# gfx_compositor

- Parametrised, pipelined successor to the single-stage graphics layer mux.
- Per pixel it:
  - converts VGA beam counters to rotated playfield coordinates;
  - issues the maze RAM read address;
  - composites NSPR sprite layers over the maze in fixed index priority, with per-layer enables;
  - registers the final colour.
- It also generates the frame-synchronous animation step that all sprite renderers share, replacing button-driven animation.
- It sits between the VGA timing generator and the DAC, with sprite renderers and the maze ping-pong RAM hanging off its coordinate and address outputs.

## Interface
- NSPR, 5, number of sprite layers; index 0 has highest priority.
- XMAX, 240, playfield width in pixels.
- YMAX, 320, playfield height in pixels.
- YOFFSET, 24, first playfield row held in maze RAM.
- ROW_WORDS, 264, RAM words per playfield column.
- ADDR_W, 16, RAM address width.
- ANIM_DIV, 8, frames per animation step; must be ≥1.
- TRANSP, 8'h00, colour value treated as transparent.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- hc  in  10  horizontal beam counter.
- vc  in  10  vertical beam counter.
- layer_en  in  NSPR  per-layer enable; bit i gates sprite i.
- sprite_color  in  8*NSPR  layer colours; layer i is bits [8i+7:8i]; driven combinationally from xpos/ypos.
- maze_color  in  8  maze RAM read data, valid one clk after address.
- xpos  out  9  registered playfield x.
- ypos  out  9  registered playfield y.
- address  out  ADDR_W  registered maze RAM address.
- color  out  8  registered composited pixel.
- frame_start  out  1  one-clk pulse per frame.
- anim_step  out  2  free-running animation counter.

## Operation
- Stage 1 (registered from hc/vc):
  - If hc<640 and vc<480: xpos=XMAX-1-(vc>>1), ypos=hc>>1.
  - Else if vc<480: xpos=XMAX-1-(vc>>1), ypos=YMAX-1.
  - Else: xpos=0, ypos=0.
  - active1 = (hc<640 && vc<480).
- Address:
  - If YOFFSET ≤ ypos < YOFFSET+ROW_WORDS: address = xpos*ROW_WORDS + (ypos-YOFFSET).
  - Else address = all ones.
  - Computed from the next-state xpos/ypos and registered alongside them.
  - The product is computed at ADDR_W+2 bits, then truncated; max in-range value is 63359.
- Stage 2: register sprite_color, layer_en, active1 → spr2, en2, active2. maze_color is valid in this stage.
- Stage 3 composite, registered into color:
  - If !active2: 0.
  - Else: lowest i with en2[i] and spr2[i]≠TRANSP.
  - Else maze_color if ≠TRANSP.
  - Else 0.
- Frame timer:
  - frame_start=1 for one clk after the clk where hc==0 && vc==0.
  - frame_cnt counts frame_start pulses 0..ANIM_DIV-1. On wrap to 0, anim_step increments mod 4.

## Timing
- Latency: hc/vc sampled at edge k → xpos/ypos/address after edge k+1; color after edge k+3.
- Throughput: one pixel per clk, no stalls.
- Reset values:
  - xpos=0, ypos=0, address=all ones.
  - color=0, frame_start=0, anim_step=0.
  - active1=active2=0, frame_cnt=0.
- Reset mid-frame: the pipeline flushes to blank. color stays 0 until three valid pixels have entered. Animation restarts from step 0 at the next frame_start.
- hc==0 && vc==0 held for several clks: frame_start pulses once, rising-qualified on the match condition.
- ANIM_DIV=1: anim_step advances every frame.
- anim_step wraps 3→0.
- layer_en changes take effect for the pixel sampled in the same clk as the sprite colour (stage 2 alignment).

## Configuration
- GFX_TILE_GRID_EN, when defined: in stage 3, an active pixel with no visible sprite, transparent maze, and xpos[2:0]==0 or ypos[2:0]==0 outputs 8'b01001001 (debug tile grid). xpos/ypos[2:0] are delayed to stage 2 for this.
- Undefined: such pixels output 0; no extra registers are present.

## Structure
- gfx_pkg holds:
  - colour constants RED, PNK, CYN, ORG, YLW, WHT, CRM, BLU, BLK, GRID;
  - XMAX, YMAX, YOFFSET, ROW_WORDS defaults;
  - the ADDR_MAX constant.
- One sub-module, gfx_frame_timer, owns frame_start, frame_cnt and anim_step. It is parametrised by ANIM_DIV.

## Test plan
- rst high 2 clks with hc=100, vc=10 → color=0, address=16'hFFFF, anim_step=0, frame_start=0.
- Address mapping:
  - hc=0, vc=0 → one clk later xpos=239, ypos=0, address=16'hFFFF.
  - hc=100, vc=10 → xpos=234, ypos=50, address=61802.
- Priority, with maze=BLU and all enabled:
  - spr0=0, spr1=PNK, spr2=RED → color=PNK three clks after hc/vc.
  - Clear layer_en[1] → RED.
  - All sprites 0 → BLU.
- Blanking: hc=700, vc=10, spr0=RED → color=0, ypos=319. Also vc=500 → xpos=0, ypos=0, color=0.
- ANIM_DIV=2 over 5 frames → anim_step 0,0,1,1,2 at successive frame_start. Assert rst mid-frame → anim_step=0 and stays 0 for the next frame. Run 8 steps → wraps 3→0.
- GFX_TILE_GRID_EN defined, all layers and maze transparent, xpos=232 → color=8'b01001001. Same stimulus undefined → 0.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared constants for the graphics compositor: colours and playfield geometry.
// Palette entries are RGB332; GRID is the debug tile-grid colour.
package gfx_pkg;

  localparam logic [7:0] RED  = 8'hE0;
  localparam logic [7:0] PNK  = 8'hF2;
  localparam logic [7:0] CYN  = 8'h1F;
  localparam logic [7:0] ORG  = 8'hEC;
  localparam logic [7:0] YLW  = 8'hFC;
  localparam logic [7:0] WHT  = 8'hFF;
  localparam logic [7:0] CRM  = 8'hFE;
  localparam logic [7:0] BLU  = 8'h03;
  localparam logic [7:0] BLK  = 8'h00;
  localparam logic [7:0] GRID = 8'b0100_1001;

  localparam int XMAX_DEF      = 240;
  localparam int YMAX_DEF      = 320;
  localparam int YOFFSET_DEF   = 24;
  localparam int ROW_WORDS_DEF = 264;

  localparam int ADDR_MAX = XMAX_DEF * ROW_WORDS_DEF - 1;

endpackage

// File: rtl/gfx_if.sv
// Beam-counter, layer-colour and pixel-output bundle of the compositor.
// master = timing/sprite/RAM side, slave = compositor.
interface gfx_if #(
  parameter int NSPR   = 5,
  parameter int ADDR_W = 16
);

  logic [9:0]          hc;
  logic [9:0]          vc;
  logic [NSPR-1:0]     layer_en;
  logic [8*NSPR-1:0]   sprite_color;
  logic [7:0]          maze_color;
  logic [8:0]          xpos;
  logic [8:0]          ypos;
  logic [ADDR_W-1:0]   address;
  logic [7:0]          color;
  logic                frame_start;
  logic [1:0]          anim_step;

  modport master (
    output hc, vc, layer_en, sprite_color, maze_color,
    input  xpos, ypos, address, color, frame_start, anim_step
  );

  modport slave (
    input  hc, vc, layer_en, sprite_color, maze_color,
    output xpos, ypos, address, color, frame_start, anim_step
  );

endinterface

// File: rtl/gfx_frame_timer.sv
// Frame-start pulse and shared animation step, one step per ANIM_DIV frames.
// The pulse is edge-qualified so a held (0,0) beam position fires once.
module gfx_frame_timer import gfx_pkg::*; #(
  parameter int ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sof_i,
  output logic       frame_start_o,
  output logic [1:0] anim_step_o
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic          sof_q;
  logic          fs_q;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]    anim_q, anim_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    anim_d      = anim_q;
    if (fs_q) begin
      if (int'(frame_cnt_q) == ANIM_DIV - 1) begin
        frame_cnt_d = '0;
        anim_d      = anim_q + 2'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sof_q       <= 1'b0;
      fs_q        <= 1'b0;
      frame_cnt_q <= '0;
      anim_q      <= 2'd0;
    end else begin
      sof_q       <= sof_i;
      fs_q        <= sof_i && !sof_q;
      frame_cnt_q <= frame_cnt_d;
      anim_q      <= anim_d;
    end
  end

  assign frame_start_o = fs_q;
  assign anim_step_o   = anim_q;

endmodule

// File: rtl/gfx_compositor.sv
// Three-stage pixel compositor: beam->playfield mapping, maze address, layer mux.
// Optional debug tile grid on transparent pixels: GFX_TILE_GRID_EN.
module gfx_compositor import gfx_pkg::*; #(
  parameter int          NSPR      = 5,
  parameter int          XMAX      = XMAX_DEF,
  parameter int          YMAX      = YMAX_DEF,
  parameter int          YOFFSET   = YOFFSET_DEF,
  parameter int          ROW_WORDS = ROW_WORDS_DEF,
  parameter int          ADDR_W    = 16,
  parameter int          ANIM_DIV  = 8,
  parameter logic [7:0]  TRANSP    = 8'h00
) (
  input logic  clk,
  input logic  rst,
  gfx_if.slave bus
);

  localparam int AW2 = ADDR_W + 2;

  logic              act_d, act1_q, act2_q;
  logic [8:0]        xpos_d, xpos_q;
  logic [8:0]        ypos_d, ypos_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [AW2-1:0]    prod;
  logic [8*NSPR-1:0] spr2_q;
  logic [NSPR-1:0]   en2_q;
  logic [7:0]        color_d, color_q;

  assign act_d = (bus.hc < 10'd640) && (bus.vc < 10'd480);

  always_comb begin
    xpos_d = 9'd0;
    ypos_d = 9'd0;
    if (bus.vc < 10'd480) begin
      xpos_d = 9'(XMAX - 1 - int'(bus.vc[9:1]));
      ypos_d = act_d ? bus.hc[9:1] : 9'(YMAX - 1);
    end
    prod = AW2'(xpos_d) * AW2'(ROW_WORDS)
         + AW2'(ypos_d) - AW2'(YOFFSET);
    addr_d = '1;
    if (int'(ypos_d) >= YOFFSET &&
        int'(ypos_d) < YOFFSET + ROW_WORDS)
      addr_d = ADDR_W'(prod);
  end

`ifdef GFX_TILE_GRID_EN
  logic [2:0] gx2_q, gy2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gx2_q <= 3'd0;
      gy2_q <= 3'd0;
    end else begin
      gx2_q <= xpos_q[2:0];
      gy2_q <= ypos_q[2:0];
    end
  end
`endif

  // Lowest enabled, non-transparent layer wins; the loop runs high-to-low.
  always_comb begin
    color_d = BLK;
    if (act2_q) begin
      if (bus.maze_color != TRANSP)
        color_d = bus.maze_color;
`ifdef GFX_TILE_GRID_EN
      else if (gx2_q == 3'd0 || gy2_q == 3'd0)
        color_d = GRID;
`endif
      for (int i = NSPR - 1; i >= 0; i--)
        if (en2_q[i] && spr2_q[8*i +: 8] != TRANSP)
          color_d = spr2_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_q  <= 9'd0;
      ypos_q  <= 9'd0;
      addr_q  <= '1;
      act1_q  <= 1'b0;
      spr2_q  <= '0;
      en2_q   <= '0;
      act2_q  <= 1'b0;
      color_q <= 8'd0;
    end else begin
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      addr_q  <= addr_d;
      act1_q  <= act_d;
      spr2_q  <= bus.sprite_color;
      en2_q   <= bus.layer_en;
      act2_q  <= act1_q;
      color_q <= color_d;
    end
  end

  gfx_frame_timer #(
    .ANIM_DIV (ANIM_DIV)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .sof_i         (bus.hc == 10'd0 && bus.vc == 10'd0),
    .frame_start_o (bus.frame_start),
    .anim_step_o   (bus.anim_step)
  );

  assign bus.xpos    = xpos_q;
  assign bus.ypos    = ypos_q;
  assign bus.address = addr_q;
  assign bus.color   = color_q;

endmodule

// File: tb/tb_gfx_compositor.sv
// Directed bench for gfx_compositor (ANIM_DIV=2).
// Grid expectation follows GFX_TILE_GRID_EN.
module tb_gfx_compositor;
  import gfx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  gfx_if #(.NSPR(5), .ADDR_W(16)) bus ();

  gfx_compositor #(.ANIM_DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v);
    bus.hc = h;
    bus.vc = v;
  endtask

  task automatic do_frame(output logic fs, output logic [1:0] an);
    pix(10'd0, 10'd0);
    tick();
    fs = bus.frame_start;
    an = bus.anim_step;
    pix(10'd5, 10'd5);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix(10'd100, 10'd10);
    tick();
    tick();
    n_cmp++; if (bus.color !== 8'h00) begin n_err++; $display("FAIL rst_color: got %h want 00", bus.color); end
    n_cmp++; if (bus.address !== 16'hFFFF) begin n_err++; $display("FAIL rst_addr: got %h want ffff", bus.address); end
    n_cmp++; if (bus.anim_step !== 2'd0) begin n_err++; $display("FAIL rst_anim: got %0d want 0", bus.anim_step); end
    n_cmp++; if (bus.frame_start !== 1'b0) begin n_err++; $display("FAIL rst_fs: got %b want 0", bus.frame_start); end
    n_cmp++; if (bus.xpos !== 9'd0 || bus.ypos !== 9'd0) begin n_err++; $display("FAIL rst_pos: got %0d,%0d want 0,0", bus.xpos, bus.ypos); end
    rst = 1'b0;
  endtask

  task automatic test_address();
    logic [9:0]  h [6] = '{10'd0, 10'd100, 10'd48, 10'd574, 10'd576, 10'd46};
    logic [9:0]  v [6] = '{10'd0, 10'd10, 10'd0, 10'd0, 10'd0, 10'd0};
    logic [8:0]  ex [6] = '{9'd239, 9'd234, 9'd239, 9'd239, 9'd239, 9'd239};
    logic [8:0]  ey [6] = '{9'd0, 9'd50, 9'd24, 9'd287, 9'd288, 9'd23};
    logic [15:0] ea [6] = '{16'hFFFF, 16'd61802, 16'd63096, 16'd63359, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 6; i++) begin
      pix(h[i], v[i]);
      tick();
      n_cmp++; if (bus.xpos !== ex[i] || bus.ypos !== ey[i]) begin n_err++; $display("FAIL addr_pos[%0d]: got %0d,%0d want %0d,%0d", i, bus.xpos, bus.ypos, ex[i], ey[i]); end
      n_cmp++; if (bus.address !== ea[i]) begin n_err++; $display("FAIL addr_val[%0d]: got %0d want %0d", i, bus.address, ea[i]); end
    end
  endtask

  task automatic test_priority();
    bus.maze_color = BLU;
    bus.layer_en = 5'b11111;
    bus.sprite_color = {8'h00, 8'h00, RED, PNK, 8'h00};
    pix(10'd100, 10'd10);
    repeat (3) tick();
    n_cmp++; if (bus.color !== PNK) begin n_err++; $display("FAIL prio_pnk: got %h want %h", bus.color, PNK); end
    bus.layer_en = 5'b11101;
    repeat (3) tick();
    n_cmp++; if (bus.color !== RED) begin n_err++; $display("FAIL prio_en1_off: got %h want %h", bus.color, RED); end
    bus.layer_en = 5'b11111;
    bus.sprite_color = '0;
    repeat (3) tick();
    n_cmp++; if (bus.color !== BLU) begin n_err++; $display("FAIL prio_maze: got %h want %h", bus.color, BLU); end
    bus.sprite_color = {CYN, YLW, 8'h00, 8'h00, 8'h00};
    bus.layer_en = 5'b10111;
    repeat (3) tick();
    n_cmp++; if (bus.color !== CYN) begin n_err++; $display("FAIL prio_spr4: got %h want %h", bus.color, CYN); end
  endtask

  task automatic test_blank();
    bus.maze_color = BLU;
    bus.layer_en = 5'b11111;
    bus.sprite_color = {32'h0, RED};
    pix(10'd700, 10'd10);
    tick();
    n_cmp++; if (bus.xpos !== 9'd234 || bus.ypos !== 9'd319) begin n_err++; $display("FAIL blank_h_pos: got %0d,%0d want 234,319", bus.xpos, bus.ypos); end
    n_cmp++; if (bus.address !== 16'hFFFF) begin n_err++; $display("FAIL blank_h_addr: got %h want ffff", bus.address); end
    tick(); tick();
    n_cmp++; if (bus.color !== 8'h00) begin n_err++; $display("FAIL blank_h_color: got %h want 00", bus.color); end
    pix(10'd100, 10'd500);
    tick();
    n_cmp++; if (bus.xpos !== 9'd0 || bus.ypos !== 9'd0) begin n_err++; $display("FAIL blank_v_pos: got %0d,%0d want 0,0", bus.xpos, bus.ypos); end
    tick(); tick();
    n_cmp++; if (bus.color !== 8'h00) begin n_err++; $display("FAIL blank_v_color: got %h want 00", bus.color); end
    pix(10'd639, 10'd479);
    tick();
    n_cmp++; if (bus.xpos !== 9'd0 || bus.ypos !== 9'd319) begin n_err++; $display("FAIL edge_pos: got %0d,%0d want 0,319", bus.xpos, bus.ypos); end
    tick(); tick();
    n_cmp++; if (bus.color !== RED) begin n_err++; $display("FAIL edge_color: got %h want %h", bus.color, RED); end
  endtask

  task automatic test_flush_latency();
    bus.sprite_color = {32'h0, RED};
    bus.layer_en = 5'b11111;
    pix(10'd100, 10'd10);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.color !== 8'h00) begin n_err++; $display("FAIL flush_rst: got %h want 00", bus.color); end
    tick(); tick();
    n_cmp++; if (bus.color !== 8'h00) begin n_err++; $display("FAIL flush_k2: got %h want 00", bus.color); end
    tick();
    n_cmp++; if (bus.color !== RED) begin n_err++; $display("FAIL flush_k3: got %h want %h", bus.color, RED); end
  endtask

  task automatic test_grid();
    logic [7:0] exp_c;
`ifdef GFX_TILE_GRID_EN
    exp_c = 8'b0100_1001;
`else
    exp_c = 8'h00;
`endif
    bus.sprite_color = '0;
    bus.maze_color = 8'h00;
    bus.layer_en = 5'b11111;
    pix(10'd100, 10'd14);
    tick();
    n_cmp++; if (bus.xpos !== 9'd232) begin n_err++; $display("FAIL grid_xpos: got %0d want 232", bus.xpos); end
    tick(); tick();
    n_cmp++; if (bus.color !== exp_c) begin n_err++; $display("FAIL grid_on: got %h want %h", bus.color, exp_c); end
    pix(10'd102, 10'd10);
    repeat (3) tick();
    n_cmp++; if (bus.color !== 8'h00) begin n_err++; $display("FAIL grid_off: got %h want 00", bus.color); end
  endtask

  task automatic test_anim();
    logic       fs;
    logic [1:0] an;
    logic [1:0] exp_a [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    pix(10'd5, 10'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_frame(fs, an);
      n_cmp++; if (fs !== 1'b1) begin n_err++; $display("FAIL anim_fs[%0d]: got %b want 1", k, fs); end
      n_cmp++; if (an !== exp_a[k]) begin n_err++; $display("FAIL anim_step[%0d]: got %0d want %0d", k, an, exp_a[k]); end
    end
    pix(10'd0, 10'd0);
    tick();
    n_cmp++; if (bus.frame_start !== 1'b1) begin n_err++; $display("FAIL hold_fs0: got %b want 1", bus.frame_start); end
    tick();
    n_cmp++; if (bus.frame_start !== 1'b0) begin n_err++; $display("FAIL hold_fs1: got %b want 0", bus.frame_start); end
    tick();
    n_cmp++; if (bus.frame_start !== 1'b0) begin n_err++; $display("FAIL hold_fs2: got %b want 0", bus.frame_start); end
    pix(10'd5, 10'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.anim_step !== 2'd0) begin n_err++; $display("FAIL midrst_anim: got %0d want 0", bus.anim_step); end
    for (int k = 0; k < 3; k++) begin
      do_frame(fs, an);
      n_cmp++; if (an !== ((k == 2) ? 2'd1 : 2'd0)) begin n_err++; $display("FAIL midrst_step[%0d]: got %0d", k, an); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      do_frame(fs, an);
      n_cmp++; if (an !== 2'(((k - 1) / 2) % 4)) begin n_err++; $display("FAIL wrap_step[%0d]: got %0d want %0d", k, an, ((k - 1) / 2) % 4); end
    end
  endtask

  initial begin
    bus.hc = '0;
    bus.vc = '0;
    bus.layer_en = '0;
    bus.sprite_color = '0;
    bus.maze_color = '0;
    test_reset();
    test_address();
    test_priority();
    test_blank();
    test_flush_latency();
    test_grid();
    test_anim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
